// File: rtl/acc_cpu_sequencer.sv
// acc_cpu_sequencer: fetch/decode/execute sequencer for an 8-bit accumulator CPU
// driving a 16x8 synchronous memory (registered read data, one-cycle strobes).
module acc_cpu_sequencer #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic              mem_r,
    output logic              mem_w,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ac,
    output logic [ADDR_W-1:0] pc,
    output logic              carry,
    output logic              halted
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_FWAIT, S_EXEC, S_MWAIT, S_HALT} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d, ac_q, ac_d;
    logic              carry_q, carry_d, halted_q, halted_d;
    logic [1:0]        op, sub;
    logic [ADDR_W-1:0] opa;

    assign op  = ir_q[DATA_W-1:DATA_W-2];
    assign sub = ir_q[DATA_W-3:DATA_W-4];
    assign opa = ir_q[ADDR_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            ac_q     <= '0;
            carry_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            ac_q     <= ac_d;
            carry_q  <= carry_d;
            halted_q <= halted_d;
        end
    end

    // Memory strobes depend only on state/ir/pc/ac, never on mem_rdata.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        ac_d      = ac_q;
        carry_d   = carry_q;
        halted_d  = halted_q;
        mem_r     = 1'b0;
        mem_w     = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state_q)
            S_IDLE:  state_d = run ? S_FETCH : S_IDLE;
            S_FETCH: begin
                mem_r    = 1'b1;
                mem_addr = pc_q;
                state_d  = S_FWAIT;
            end
            S_FWAIT: begin
                ir_d    = mem_rdata;
                pc_d    = pc_q + 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                if (!op[1]) begin
                    mem_r    = 1'b1;
                    mem_addr = opa;
                    state_d  = S_MWAIT;
                end else if (op == 2'b10) begin
                    mem_w     = 1'b1;
                    mem_addr  = opa;
                    mem_wdata = ac_q;
                end else if (sub == 2'b00) begin
                    pc_d = opa;
                end else if (sub == 2'b11) begin
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end
            end
            S_MWAIT: begin
                if (op[0]) ac_d = mem_rdata;
                else {carry_d, ac_d} = {1'b0, ac_q} + {1'b0, mem_rdata};
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    assign ac     = ac_q;
    assign pc     = pc_q;
    assign carry  = carry_q;
    assign halted = halted_q;
endmodule
